// File: rtl/clm_rand_supply_pkg.sv
// Shared types and constants for the CLM mask-randomness supply.
// Default configuration is D=1 (ten 8-bit mask words per multiplication).
package clm_rand_supply_pkg;

  localparam int DEF_D      = 1;
  localparam int DEF_POLY_W = 8;
  localparam int N_MASK     = 9 + DEF_D;

  localparam int              LFSR_W     = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] LFSR_SEED0 = 32'hACE1_2468;

  typedef logic [DEF_POLY_W-1:0] red_poly_t;
  typedef red_poly_t rand_vec_t [0:N_MASK-1];

  // One right-shifting Galois step for x^32+x^22+x^2+x+1.
  function automatic logic [LFSR_W-1:0] lfsr_step1(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/clm_rand_supply_if.sv
// Seed control and multiplier-facing mask handshake for clm_rand_supply.
interface clm_rand_supply_if
  import clm_rand_supply_pkg::*;
#(
  parameter int D      = DEF_D,
  parameter int POLY_W = DEF_POLY_W
);
  localparam int N = 9 + D;

  logic                  seed_load_i;
  logic [LFSR_W-1:0]     seed_i;
  logic                  req_i;
  logic                  rdy_o;
  logic [N*POLY_W-1:0]   vect_o;
  logic                  underflow_o;

  modport master (
    output seed_load_i, seed_i, req_i,
    input  rdy_o, vect_o, underflow_o
  );

  modport slave (
    input  seed_load_i, seed_i, req_i,
    output rdy_o, vect_o, underflow_o
  );

endinterface

// File: rtl/clm_lfsr_step.sv
// Advances the Galois LFSR by STEPS positions in one combinational hop;
// word is the low STEPS bits of the advanced state.
module clm_lfsr_step
  import clm_rand_supply_pkg::*;
#(
  parameter int STEPS = DEF_POLY_W
) (
  input  logic [LFSR_W-1:0] lfsr,
  output logic [LFSR_W-1:0] lfsr_next,
  output logic [STEPS-1:0]  word
);

  always_comb begin
    logic [LFSR_W-1:0] s;
    s = lfsr;
    for (int i = 0; i < STEPS; i++) begin
      s = lfsr_step1(s);
    end
    lfsr_next = s;
  end

  assign word = lfsr_next[STEPS-1:0];

endmodule

// File: rtl/clm_rand_supply.sv
// Fills a shadow buffer of 9+D mask words one per cycle, then hands the whole buffer to a held
// output on each accepted request; rdy_o rises N cycles after reset, seed load or accepted request.
module clm_rand_supply
  import clm_rand_supply_pkg::*;
#(
  parameter int                D      = DEF_D,
  parameter int                POLY_W = DEF_POLY_W,
  parameter logic [LFSR_W-1:0] SEED0  = LFSR_SEED0
) (
  input  logic               clk,
  input  logic               rst,
  clm_rand_supply_if.slave   bus
);

  localparam int N     = 9 + D;
  localparam int IDX_W = $clog2(N);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]          state;
  logic [IDX_W-1:0]    idx;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   lfsr_next;
  logic [POLY_W-1:0]   word;
  logic [N*POLY_W-1:0] buffer;
  logic [N*POLY_W-1:0] vect_q;
  logic                underflow_q;

  clm_lfsr_step #(
    .STEPS (POLY_W)
  ) u_step (
    .lfsr      (lfsr),
    .lfsr_next (lfsr_next),
    .word      (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= SEED0;
      state       <= ST_FILL;
      idx         <= '0;
      buffer      <= '0;
      vect_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      // A request is served from the buffer as it stood before any same-cycle seed load.
      if (bus.req_i) begin
        if (state == ST_FULL) begin
          vect_q <= buffer;
        end else begin
          underflow_q <= 1'b1;
        end
      end

      if (bus.seed_load_i) begin
        lfsr  <= (bus.seed_i == '0) ? SEED0 : bus.seed_i;
        state <= ST_FILL;
        idx   <= '0;
      end else if (state == ST_FILL) begin
        buffer[idx*POLY_W +: POLY_W] <= word;
        lfsr                         <= lfsr_next;
        if (idx == IDX_W'(N - 1)) begin
          state <= ST_FULL;
          idx   <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (bus.req_i) begin
        state <= ST_FILL;
        idx   <= '0;
      end
    end
  end

  assign bus.rdy_o       = (state == ST_FULL);
  assign bus.vect_o      = vect_q;
  assign bus.underflow_o = underflow_q;

endmodule
